reg_file_bypass: RTL
====================

REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 SHALL have parameter ADDR_W, default 4, register address bits; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port WriteReg  input  1  write enable for the write port.
REQ-007 SHALL have port DstReg  input  ADDR_W  write address.
REQ-008 SHALL have port DstData  input  WIDTH  write data.
REQ-009 SHALL have port Reserve  input  1  marks register ResReg busy (scoreboard set).
REQ-010 SHALL have port ResReg  input  ADDR_W  reservation address.
REQ-011 SHALL have port SrcReg1  input  ADDR_W  read port 1 address.
REQ-012 SHALL have port SrcReg2  input  ADDR_W  read port 2 address.
REQ-013 SHALL have port SrcData1  output  WIDTH  read port 1 data.
REQ-014 SHALL have port SrcData2  output  WIDTH  read port 2 data.
REQ-015 SHALL have port Busy1  output  1  register SrcReg1 has an outstanding reservation.
REQ-016 SHALL have port Busy2  output  1  register SrcReg2 has an outstanding reservation.

Function
REQ-017 SHALL hold DEPTH x WIDTH storage plus one busy bit per register; no tristate bitlines, reads are mux-based.
REQ-018 SHALL write DstData into register DstReg on the rising edge when WriteReg=1 and rst=0; write latency 1 cycle.
REQ-019 SHALL drive SrcDataN combinationally from stored register SrcRegN (zero read latency).
REQ-020 SHALL bypass: when WriteReg=1, rst=0 and DstReg==SrcRegN (excluding reg 0 if ZERO_REG=1), SrcDataN SHALL equal DstData in the same cycle.
REQ-021 SHALL serve both read ports independently; both may address the same register, including the bypassed one.
REQ-022 SHALL, when ZERO_REG=1, return 0 on SrcDataN and 0 on BusyN for SrcRegN=0, regardless of writes, reservations or bypass.
REQ-023 SHALL set busy[ResReg] on the edge when Reserve=1 and rst=0.
REQ-024 SHALL clear busy[DstReg] on the edge when WriteReg=1 and rst=0.
REQ-025 SHALL, when Reserve and WriteReg target the same register in one cycle, leave busy set (new reservation wins) and store DstData.
REQ-026 SHALL drive BusyN = busy[SrcRegN], except BusyN=0 when a same-cycle write to SrcRegN clears it and no same-cycle Reserve targets SrcRegN.
REQ-027 SHALL NOT reflect a same-cycle Reserve on BusyN; the reservation is visible from the next cycle.
REQ-028 SHALL accept writes to a non-busy register (busy bit stays 0); no error flag.
REQ-029 SHALL treat all address values as valid; no out-of-range condition exists.

Reset
REQ-030 SHALL, on an edge with rst=1, clear all registers to 0 and all busy bits to 0; WriteReg and Reserve are ignored in that cycle.
REQ-031 SHALL suppress bypass while rst=1; SrcDataN shows stored contents and BusyN shows stored busy bits.
REQ-032 SHALL present SrcDataN=0 and BusyN=0 for every address in the cycle after reset is applied.

Verification
REQ-033 SHALL verify write/read: write 0xBEEF to r5, next cycle SrcReg1=5 -> SrcData1=0xBEEF; SrcReg2=6 -> 0x0000.
REQ-034 SHALL verify bypass: WriteReg=1, DstReg=3, DstData=0x1234, SrcReg1=SrcReg2=3 same cycle -> both outputs 0x1234 before the edge.
REQ-035 SHALL verify zero register (ZERO_REG=1): write 0xFFFF to r0, Reserve r0 -> SrcData1=0, Busy1=0 same and next cycle.
REQ-036 SHALL verify scoreboard: Reserve r7 -> Busy1=0 that cycle, 1 next cycle; later write r7 with 0x00AA -> Busy1=0 that cycle, SrcData1=0x00AA.
REQ-037 SHALL verify collision: Reserve r9 and write r9=0x0042 same cycle -> next cycle Busy1=1, SrcData1=0x0042.
REQ-038 SHALL verify reset mid-operation: r2=0x5555 busy, assert rst with WriteReg=1 DstReg=2 DstData=0x7777 -> next cycle SrcData1=0, Busy1=0.

Source files
------------

// File: rtl/reg_file_bypass.sv
// ---------------------------------------------------------------------------
// reg_file_bypass
//   Multi-ported register file with a per-register busy scoreboard.
//   One write port, one reservation port, two combinational read ports.
//   Each read port forwards same-cycle write data, so a read sees the value
//   being written on the upcoming edge. Register 0 can be hard-wired to zero.
//
// Parameters
//   WIDTH    : data bits per register
//   ADDR_W   : register address bits (DEPTH = 2**ADDR_W)
//   ZERO_REG : 1 -> register 0 reads as zero and ignores writes/reservations
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset (clears data and busy bits)
//   WriteReg  in   write enable
//   DstReg    in   write address
//   DstData   in   write data
//   Reserve   in   set the busy bit of ResReg
//   ResReg    in   reservation address
//   SrcReg1/2 in   read addresses
//   SrcData1/2 out read data (bypassed)
//   Busy1/2   out  outstanding reservation on the addressed register
// ---------------------------------------------------------------------------
module reg_file_bypass #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteReg,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic [WIDTH-1:0]  DstData,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ResReg,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  output logic [WIDTH-1:0]  SrcData1,
  output logic [WIDTH-1:0]  SrcData2,
  output logic              Busy1,
  output logic              Busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_zero_en;
  logic              w_dst_ok;
  logic              w_res_ok;
  logic              w_wr_act;
  logic [ADDR_W-1:0] w_src  [2];
  logic [WIDTH-1:0]  w_data [2];
  logic              w_busy [2];

  assign w_zero_en = (ZERO_REG != 0);
  assign w_dst_ok  = !(w_zero_en && (DstReg == '0));
  assign w_res_ok  = !(w_zero_en && (ResReg == '0));
  // Writes and bypass are both suppressed while reset is asserted.
  assign w_wr_act  = WriteReg && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (WriteReg && w_dst_ok) begin
        r_regs[DstReg] <= DstData;
      end
      if (WriteReg) begin
        r_busy[DstReg] <= 1'b0;
      end
      // Placed after the clear so a same-cycle reservation on the written
      // register wins and the busy bit stays set.
      if (Reserve && w_res_ok) begin
        r_busy[ResReg] <= 1'b1;
      end
    end
  end

  assign w_src[0] = SrcReg1;
  assign w_src[1] = SrcReg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_data[p] = r_regs[w_src[p]];
      w_busy[p] = r_busy[w_src[p]];
      if (w_wr_act && (DstReg == w_src[p])) begin
        w_data[p] = DstData;
        // A completing write hides the busy bit unless the same register
        // is being re-reserved; the new reservation only shows next cycle.
        if (!(Reserve && (ResReg == w_src[p]))) begin
          w_busy[p] = 1'b0;
        end
      end
      if (w_zero_en && (w_src[p] == '0)) begin
        w_data[p] = '0;
        w_busy[p] = 1'b0;
      end
    end
  end

  assign SrcData1 = w_data[0];
  assign SrcData2 = w_data[1];
  assign Busy1    = w_busy[0];
  assign Busy2    = w_busy[1];

endmodule
